instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 IAddr  output  32  SHALL carry the instruction-memory byte address (current PC).
REQ-005 IReq  output  1  SHALL carry the fetch request to instruction memory.
REQ-006 IData  input  32  SHALL carry the instruction word returned by memory.
REQ-007 IAck  input  1  SHALL mean IData is valid this cycle.
REQ-008 Stall  input  1  SHALL mean the downstream stage holds the current instruction.
REQ-009 Branch, Zero, JMP  input  1 each  SHALL carry the branch/jump decision from the main controller and ALU for the held instruction.
REQ-010 Instr  output  32  SHALL carry the registered instruction word.
REQ-011 OP  output  6  SHALL carry Instr[31:26], feeding the main controller.
REQ-012 Rs, Rt, Rd  output  5 each  SHALL carry Instr[25:21], [20:16], [15:11].
REQ-013 Imm  output  16  SHALL carry Instr[15:0].
REQ-014 PC, PCplus4  output  32 each  SHALL carry the held instruction's address and that address + 4.
REQ-015 InstrValid  output  1  SHALL mean Instr and its fields are valid for decode.

Function
REQ-016 The FSM SHALL have states IDLE, REQ and HOLD.
REQ-017 IDLE SHALL advance to REQ on the first clock edge after rst deasserts.
REQ-018 In REQ, IReq SHALL be 1 and IAddr SHALL equal PC, both held stable until IAck=1.
REQ-019 In REQ with IAck=1, the block SHALL register IData into Instr and move to HOLD; InstrValid=1 from the next cycle.
REQ-020 In HOLD with Stall=1, the block SHALL hold PC, Instr and InstrValid unchanged.
REQ-021 In HOLD with Stall=0, the block SHALL load PC with NextPC, clear InstrValid and return to REQ.
REQ-022 NextPC with JMP=1 SHALL be {PCplus4[31:28], Instr[25:0], 2'b00}.
REQ-023 NextPC with JMP=0, Branch=1, Zero=1 SHALL be PCplus4 + (sign-extended Imm << 2).
REQ-024 Otherwise NextPC SHALL be PCplus4.
REQ-025 JMP SHALL take priority when JMP and Branch are both asserted.
REQ-026 Branch, Zero and JMP SHALL be sampled only in HOLD with Stall=0 and ignored otherwise.
REQ-027 IAck outside REQ SHALL be ignored.
REQ-028 All PC arithmetic SHALL be modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
REQ-029 IAddr[1:0] SHALL always be 2'b00.
REQ-030 Minimum throughput SHALL be one instruction per 2 cycles (immediate IAck, Stall=0).

Reset
REQ-031 rst=1 SHALL immediately force state IDLE, PC=RESET_PC, Instr=0, IReq=0 and InstrValid=0.
REQ-032 Because Instr=0, OP SHALL read 6'b000000 during reset.
REQ-033 rst during REQ SHALL abandon the outstanding fetch; a late IAck SHALL be ignored.

Structure
REQ-034 A shared fetch_pkg SHALL hold the FSM state encoding, the RESET_PC default and the opcode constants R=000000, LW=100011, SW=101011, BEQ=000100, J=000010.
REQ-035 Next-PC computation SHALL be a combinational sub-module npc_calc.
REQ-036 The FSM and registers SHALL remain in instr_fetch.

Verification
REQ-037 Reset check: rst pulse mid-REQ -> IReq=0, InstrValid=0, OP=0 and PC=0 immediately; a later IAck is ignored.
REQ-038 Sequential fetch: IAck immediate, Stall=0, no branch -> IAddr steps 0, 4, 8 at one fetch per 2 cycles.
REQ-039 Wait-state fetch: IAck delayed 3 cycles at PC=8 -> IAddr=8 and IReq=1 held stable throughout; then Instr=IData and InstrValid=1.
REQ-040 BEQ taken: Instr=32'h1000_0003 at PC=0x10, Branch=1, Zero=1 -> next IAddr=0x20; with Zero=0 -> next IAddr=0x14.
REQ-041 Jump with priority: Instr=32'h0800_0040, JMP=1 and Branch=Zero=1 at PC=0x20 -> next IAddr=0x100.
REQ-042 Stall: Stall=1 for 4 cycles in HOLD -> Instr, PC and OP unchanged and IReq=0; fetch resumes the cycle after Stall falls.

Source files
------------

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction-fetch stage:
//   - fetchState_t      : FSM state encoding (IDLE, REQ, HOLD)
//   - RESET_PC_DEFAULT  : default PC loaded on reset
//   - OP_*              : opcode constants seen by the main controller
//   - branchOffset()    : sign-extended, word-scaled branch displacement
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetchState_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_J   = 6'b000010;

    // 16-bit immediate -> 32-bit byte displacement (sign-extend, then << 2)
    function automatic logic [31:0] branchOffset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/npc_calc.sv
// -----------------------------------------------------------------------------
// npc_calc
// Combinational next-PC selection for the held instruction.
// Ports:
//   pcPlus4 (in, 32)  address of held instruction + 4
//   instr   (in, 32)  held instruction word
//   jmp, branch, zero (in, 1) decision from controller / ALU
//   nextPc  (out, 32) jump target, taken-branch target, or pcPlus4
// Jump wins over branch when both are asserted.
// -----------------------------------------------------------------------------
module npc_calc
    import fetch_pkg::*;
(
    input  logic [31:0] pcPlus4,
    input  logic [31:0] instr,
    input  logic        jmp,
    input  logic        branch,
    input  logic        zero,
    output logic [31:0] nextPc
);

    // Target selection; adder wraps modulo 2^32 naturally
    always_comb begin
        nextPc = pcPlus4;
        if (jmp) begin
            nextPc = {pcPlus4[31:28], instr[25:0], 2'b00};
        end else if (branch && zero) begin
            nextPc = pcPlus4 + branchOffset(instr[15:0]);
        end else begin
            nextPc = pcPlus4;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
// Fetch stage: requests the word at PC, registers it, holds it for decode while
// the downstream stage stalls, then moves PC to the next address.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   IAddr, IReq  (out)  instruction memory address / request
//   IData, IAck  (in)   returned word / word valid this cycle
//   Stall        (in)   downstream holds the current instruction
//   Branch, Zero, JMP   next-PC decision for the held instruction
//   Instr, OP, Rs, Rt, Rd, Imm (out) registered word and its fields
//   PC, PCplus4  (out)  held instruction address and address + 4
//   InstrValid   (out)  Instr and fields valid for decode
// -----------------------------------------------------------------------------
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] IAddr,
    output logic        IReq,
    input  logic [31:0] IData,
    input  logic        IAck,
    input  logic        Stall,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        JMP,
    output logic [31:0] Instr,
    output logic [5:0]  OP,
    output logic [4:0]  Rs,
    output logic [4:0]  Rt,
    output logic [4:0]  Rd,
    output logic [15:0] Imm,
    output logic [31:0] PC,
    output logic [31:0] PCplus4,
    output logic        InstrValid
);

    fetchState_t stateR;
    fetchState_t nextState;
    logic [31:0] pcR;
    logic [31:0] instrR;
    logic        validR;
    logic        ireqR;
    logic [31:0] nextPc;

    npc_calc uNpc (
        .pcPlus4 (PCplus4),
        .instr   (instrR),
        .jmp     (JMP),
        .branch  (Branch),
        .zero    (Zero),
        .nextPc  (nextPc)
    );

    // Next-state logic; IAck only matters in REQ, Stall only in HOLD
    always_comb begin
        nextState = stateR;
        case (stateR)
            S_IDLE: nextState = S_REQ;
            S_REQ: begin
                if (IAck) begin
                    nextState = S_HOLD;
                end else begin
                    nextState = S_REQ;
                end
            end
            S_HOLD: begin
                if (!Stall) begin
                    nextState = S_REQ;
                end else begin
                    nextState = S_HOLD;
                end
            end
            default: nextState = S_IDLE;
        endcase
    end

    // State, PC, instruction and handshake registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateR <= S_IDLE;
            pcR    <= {RESET_PC[31:2], 2'b00};
            instrR <= 32'h0000_0000;
            validR <= 1'b0;
            ireqR  <= 1'b0;
        end else begin
            stateR <= nextState;
            // IReq is registered so it rises together with entry into REQ
            ireqR  <= (nextState == S_REQ);
            case (stateR)
                S_REQ: begin
                    if (IAck) begin
                        instrR <= IData;
                        validR <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (!Stall) begin
                        pcR    <= nextPc;
                        validR <= 1'b0;
                    end
                end
                default: begin
                    validR <= validR;
                end
            endcase
        end
    end

    assign IAddr      = {pcR[31:2], 2'b00};
    assign IReq       = ireqR;
    assign PC         = pcR;
    assign PCplus4    = pcR + 32'd4;
    assign Instr      = instrR;
    assign OP         = instrR[31:26];
    assign Rs         = instrR[25:21];
    assign Rt         = instrR[20:16];
    assign Rd         = instrR[15:11];
    assign Imm        = instrR[15:0];
    assign InstrValid = validR;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
// Driver walks a reference PC through a program (directed, then random),
// acting as instruction memory and downstream stage. Each fetch pushes the
// expected {address, word} into a queue; a monitor pops it when InstrValid
// rises and checks the held outputs every cycle they stay valid.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IAddr;
    logic        IReq;
    logic [31:0] IData;
    logic        IAck;
    logic        Stall;
    logic        Branch;
    logic        Zero;
    logic        JMP;
    logic [31:0] Instr;
    logic [5:0]  OP;
    logic [4:0]  Rs;
    logic [4:0]  Rt;
    logic [4:0]  Rd;
    logic [15:0] Imm;
    logic [31:0] PC;
    logic [31:0] PCplus4;
    logic        InstrValid;

    int checks = 0;
    int errors = 0;

    logic [63:0] expQ[$];
    logic [31:0] modelPc;

    instr_fetch dut (
        .clk(clk), .rst(rst), .IAddr(IAddr), .IReq(IReq), .IData(IData),
        .IAck(IAck), .Stall(Stall), .Branch(Branch), .Zero(Zero), .JMP(JMP),
        .Instr(Instr), .OP(OP), .Rs(Rs), .Rt(Rt), .Rd(Rd), .Imm(Imm),
        .PC(PC), .PCplus4(PCplus4), .InstrValid(InstrValid)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference next-PC from the architectural rules
    function automatic logic [31:0] refNext(input logic [31:0] pc, input logic [31:0] word,
                                            input bit j, input bit b, input bit z);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        off = int'($signed(word[15:0]));
        if (j)
            return (seq & 32'hF000_0000) | ((word & 32'h03FF_FFFF) * 32'd4);
        else if (b && z)
            return seq + 32'(off * 4);
        else
            return seq;
    endfunction

    // One instruction: request, optional wait states, ack, stall, decision
    task automatic fetchOne(input bit immediate, input int delay, input int stall,
                            input bit j, input bit b, input bit z, input logic [31:0] word);
        int n;
        expQ.push_back({modelPc, word});
        n = 0;
        while (!IReq && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ireq_up", 32'(IReq), 32'd1);
        if (immediate) check("ireq_latency", n, 32'd0);
        check("iaddr", IAddr, modelPc);
        repeat (delay) begin
            IAck  = 1'b0;
            IData = $urandom;
            @(negedge clk);
            check("ireq_hold", 32'(IReq), 32'd1);
            check("iaddr_hold", IAddr, modelPc);
        end
        IAck  = 1'b1;
        IData = word;
        @(negedge clk);
        repeat (stall) begin
            IAck  = 1'($urandom);
            IData = $urandom;
            Stall = 1'b1;
            {JMP, Branch, Zero} = 3'($urandom);
            @(negedge clk);
            check("ireq_stall", 32'(IReq), 32'd0);
            check("pc_stall", PC, modelPc);
        end
        IAck   = 1'b0;
        IData  = $urandom;
        Stall  = 1'b0;
        JMP    = j;
        Branch = b;
        Zero   = z;
        modelPc = refNext(modelPc, word, j, b, z);
        @(negedge clk);
        JMP = 1'b0; Branch = 1'b0; Zero = 1'b0;
    endtask

    // Monitor: pop expectation when InstrValid rises; verify fields while valid
    logic        prevValid = 1'b0;
    logic [63:0] cur;
    always @(negedge clk) begin
        check("iaddr_align", 32'(IAddr[1:0]), 32'd0);
        if (rst) begin
            prevValid <= 1'b0;
        end else begin
            if (InstrValid && !prevValid) begin
                if (expQ.size() == 0) begin
                    check("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    cur = expQ.pop_front();
                end
            end
            if (InstrValid) begin
                check("instr", Instr, cur[31:0]);
                check("pc", PC, cur[63:32]);
                check("pcplus4", PCplus4, cur[63:32] + 32'd4);
                check("op", 32'(OP), 32'(cur[31:26]));
                check("rs", 32'(Rs), 32'(cur[25:21]));
                check("rt", 32'(Rt), 32'(cur[20:16]));
                check("rd", 32'(Rd), 32'(cur[15:11]));
                check("imm", 32'(Imm), 32'(cur[15:0]));
            end
            prevValid <= InstrValid;
        end
    end

    initial begin
        rst = 1'b1; IAck = 1'b0; IData = 32'h0; Stall = 1'b0;
        Branch = 1'b0; Zero = 1'b0; JMP = 1'b0;
        modelPc = 32'h0000_0000;
        @(negedge clk);
        check("rst_ireq", 32'(IReq), 32'd0);
        check("rst_valid", 32'(InstrValid), 32'd0);
        check("rst_op", 32'(OP), 32'd0);
        check("rst_pc", PC, 32'h0);
        rst = 1'b0;

        fetchOne(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 32'h8C22_0010);
        fetchOne(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 32'hAC43_0008);

        // Reset in the middle of the fetch at PC=8; late IAck must be ignored
        check("mid_ireq", 32'(IReq), 32'd1);
        check("mid_addr", IAddr, 32'h8);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_ireq", 32'(IReq), 32'd0);
        check("mid_rst_valid", 32'(InstrValid), 32'd0);
        check("mid_rst_op", 32'(OP), 32'd0);
        check("mid_rst_pc", PC, 32'h0);
        expQ.delete();
        modelPc = 32'h0;
        @(negedge clk);
        IAck = 1'b1; IData = 32'hDEAD_BEEF;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        IAck = 1'b0;
        check("late_ack_valid", 32'(InstrValid), 32'd0);
        check("late_ack_ireq", 32'(IReq), 32'd1);
        check("late_ack_addr", IAddr, 32'h0);

        // Sequential, wait states, BEQ taken, jump priority, BEQ not taken, stall
        fetchOne(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        fetchOne(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0123_4820);
        fetchOne(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 32'h8C01_0004);
        fetchOne(1'b1, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0000_0000);
        fetchOne(1'b1, 0, 0, 1'b0, 1'b1, 1'b1, 32'h1000_0003);
        check("beq_taken", modelPc, 32'h20);
        fetchOne(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 32'h0800_0040);
        check("jump_target", modelPc, 32'h100);
        fetchOne(1'b1, 0, 0, 1'b1, 1'b0, 1'b0, 32'h0800_0004);
        fetchOne(1'b1, 0, 0, 1'b0, 1'b1, 1'b0, 32'h1000_0003);
        check("beq_not_taken", modelPc, 32'h14);
        fetchOne(1'b1, 0, 4, 1'b0, 1'b0, 1'b0, 32'h8C22_0010);
        check("after_stall_addr", modelPc, 32'h18);

        // Randomized program
        for (int i = 0; i < 60; i++) begin
            fetchOne(1'b1, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     1'($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), $urandom);
        end

        // Drain: final expectation should have been consumed
        @(negedge clk);
        check("queue_empty", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
